// File: rtl/ov7725_cfg_pkg.sv
// Shared types and constants for the OV7725 SCCB configuration sequencer.
// The SRST state exists only when OV7725_CFG_SRST_WAIT_EN is defined.
package ov7725_cfg_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_LOAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_GAP   = 3'd3,
`ifdef OV7725_CFG_SRST_WAIT_EN
        ST_SRST  = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_IDLE  = 3'd6
    } cfg_state_t;

    localparam logic        SCCB_WR_BIT    = 1'b0;
    localparam logic [15:0] SRST_ENTRY     = 16'h1280;
    localparam logic [15:0] LUT_TERMINATOR = 16'h0000;

    // Quarter-bit layout of one 3-phase write: 2 start + 27*4 data + 3 stop.
    localparam logic [6:0] START_QTRS = 7'd2;
    localparam logic [6:0] STOP_QTR0  = 7'd110;
    localparam logic [6:0] XFER_QTRS  = 7'd113;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ov7725_cfg_sequencer_engine.sv
// SCCB 3-phase write bit engine: start, 3 x (8 data + don't-care), stop,
// advancing one quarter-bit per tick. Outputs are registered.
module sccb_write_engine
    import ov7725_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_i,
    input  logic        go_i,
    input  logic [23:0] wr_bytes_i,
    output logic        sio_c_o,
    output logic        sio_d_oe_o,
    output logic        eng_done_o
);

    logic        active_q;
    logic [6:0]  qcnt_q;
    logic [26:0] frame;
    logic [6:0]  qrel;
    logic [4:0]  bit_idx;
    logic        c_d;
    logic        oe_d;

    // A 1 in the frame means "release SIO_D"; the 9th bit of each phase is the don't-care.
    assign frame   = {wr_bytes_i[23:16], 1'b1, wr_bytes_i[15:8], 1'b1, wr_bytes_i[7:0], 1'b1};
    assign qrel    = qcnt_q - START_QTRS;
    assign bit_idx = qrel[6:2];

    always_comb begin
        c_d  = 1'b1;
        oe_d = 1'b0;
        if (qcnt_q < START_QTRS) begin
            c_d  = 1'b1;
            oe_d = 1'b1;
        end else if (qcnt_q < STOP_QTR0) begin
            c_d  = qrel[1];
            oe_d = ~frame[5'd26 - bit_idx];
        end else if (qcnt_q == STOP_QTR0) begin
            c_d  = 1'b0;
            oe_d = 1'b1;
        end else if (qcnt_q == STOP_QTR0 + 7'd1) begin
            c_d  = 1'b1;
            oe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            qcnt_q     <= '0;
            sio_c_o    <= 1'b1;
            sio_d_oe_o <= 1'b0;
            eng_done_o <= 1'b0;
        end else begin
            eng_done_o <= 1'b0;
            if (!active_q) begin
                if (go_i) begin
                    active_q <= 1'b1;
                    qcnt_q   <= '0;
                end
            end else if (tick_i) begin
                if (qcnt_q == XFER_QTRS) begin
                    active_q   <= 1'b0;
                    eng_done_o <= 1'b1;
                    sio_c_o    <= 1'b1;
                    sio_d_oe_o <= 1'b0;
                end else begin
                    sio_c_o    <= c_d;
                    sio_d_oe_o <= oe_d;
                    qcnt_q     <= qcnt_q + 7'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ov7725_cfg_sequencer.sv
// OV7725 register-table sequencer: walks the LUT and writes every entry over SCCB.
// Define OV7725_CFG_SRST_WAIT_EN to add a settle wait after the COM7 soft-reset entry.
module ov7725_cfg_sequencer
    import ov7725_cfg_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCCB_FREQ_HZ = 100_000,
    parameter int START_IDX    = 2,
    parameter int LUT_SIZE     = 4,
    parameter int PWRUP_CYCLES = 1_000_000,
    parameter int GAP_CYCLES   = 1000,
    parameter int SRST_CYCLES  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  lut_index,
    input  logic [15:0] lut_data,
    input  logic [7:0]  slave_addr,
    output logic        sio_c,
    output logic        sio_d_oe,
    output logic        busy,
    output logic        cfg_done
);

    localparam int QDIV_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int TICK_W   = $clog2(QDIV + 1);
    localparam int WAIT_MAX = max3(PWRUP_CYCLES, GAP_CYCLES, SRST_CYCLES);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int LAST_IDX = START_IDX + LUT_SIZE - 1;

    localparam logic [7:0]        START_IDX_B = 8'(START_IDX);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(QDIV - 1);
    localparam logic [WAIT_W-1:0] PWRUP_LAST  = WAIT_W'(PWRUP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST    = WAIT_W'(GAP_CYCLES - 1);
`ifdef OV7725_CFG_SRST_WAIT_EN
    localparam logic [WAIT_W-1:0] SRST_LAST   = WAIT_W'(SRST_CYCLES - 1);
`endif

    cfg_state_t        state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_q;
    logic [7:0]        lut_index_q;
    logic [23:0]       wr_bytes_q;
    logic              go_q;
    logic              busy_q;
    logic              cfg_done_q;
    logic              eng_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            tick_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            wait_q      <= '0;
            lut_index_q <= START_IDX_B;
            wr_bytes_q  <= '0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                ST_PWRUP: begin
                    busy_q <= 1'b1;
                    if (wait_q == PWRUP_LAST) begin
                        wait_q  <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (lut_data == LUT_TERMINATOR || int'(lut_index_q) > LAST_IDX) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        cfg_done_q <= 1'b1;
                    end else begin
                        wr_bytes_q <= {(slave_addr & 8'hFE) | {7'd0, SCCB_WR_BIT}, lut_data};
                        go_q       <= 1'b1;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eng_done) begin
                        lut_index_q <= lut_index_q + 8'd1;
                        wait_q      <= '0;
`ifdef OV7725_CFG_SRST_WAIT_EN
                        state_q     <= (wr_bytes_q[15:0] == SRST_ENTRY) ? ST_SRST : ST_GAP;
`else
                        state_q     <= ST_GAP;
`endif
                    end
                end
`ifdef OV7725_CFG_SRST_WAIT_EN
                // The sensor ignores SCCB while it recovers from a COM7 soft reset.
                ST_SRST: begin
                    if (wait_q == SRST_LAST) begin
                        wait_q  <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
`endif
                ST_GAP: begin
                    if (wait_q == GAP_LAST) begin
                        wait_q  <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_DONE, ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_PWRUP;
                        wait_q      <= '0;
                        lut_index_q <= START_IDX_B;
                        cfg_done_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sccb_write_engine u_engine (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_q),
        .go_i       (go_q),
        .wr_bytes_i (wr_bytes_q),
        .sio_c_o    (sio_c),
        .sio_d_oe_o (sio_d_oe),
        .eng_done_o (eng_done)
    );

    assign lut_index = lut_index_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_ov7725_cfg_sequencer.sv
// Self-checking bench for ov7725_cfg_sequencer: a bus-level model predicts the
// SIO_C/SIO_D waveform of each expected write and decodes the bytes off the bus.
`timescale 1ns/1ps
module tb_ov7725_cfg_sequencer;

    localparam int CLK_HZ    = 4_000_000;
    localparam int SCCB_HZ   = 1_000_000;
    localparam int QDIV      = (CLK_HZ / (4 * SCCB_HZ) < 1) ? 1 : CLK_HZ / (4 * SCCB_HZ);
    localparam int PWRUP     = 10;
    localparam int GAP       = 5;
    localparam int SRST      = 20;
    localparam int START_IDX = 2;
    localparam int LUT_SIZE  = 4;
    localparam int XFER_Q    = 113;
`ifdef OV7725_CFG_SRST_WAIT_EN
    localparam int SRST_EXTRA = SRST;
`else
    localparam int SRST_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  slave_addr = 8'h42;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        sio_c, sio_d_oe, busy, cfg_done;
    logic [15:0] lut_mem [0:255];

    assign lut_data = lut_mem[lut_index];

    ov7725_cfg_sequencer #(
        .CLK_FREQ_HZ (CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .START_IDX(START_IDX),
        .LUT_SIZE    (LUT_SIZE), .PWRUP_CYCLES(PWRUP), .GAP_CYCLES(GAP), .SRST_CYCLES(SRST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
        .slave_addr(slave_addr), .sio_c(sio_c), .sio_d_oe(sio_d_oe), .busy(busy), .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Expected bus levels for quarter q of a write carrying bytes b (slave, reg, data).
    function automatic logic [1:0] model_wave(input int q, input logic [23:0] b);
        logic c, oe;
        int bit_n, ph, byte_n, pos;
        c = 1'b1;
        oe = 1'b0;
        if (q < 2) begin
            c = 1'b1; oe = 1'b1;
        end else if (q < 2 + 27 * 4) begin
            bit_n  = (q - 2) / 4;
            ph     = (q - 2) % 4;
            byte_n = bit_n / 9;
            pos    = bit_n % 9;
            c      = (ph >= 2);
            oe     = (pos == 8) ? 1'b0 : ~b[23 - byte_n * 8 - pos];
        end else if (q == 110) begin
            c = 1'b0; oe = 1'b1;
        end else if (q == 111) begin
            c = 1'b1; oe = 1'b1;
        end
        return {c, oe};
    endfunction

    logic [23:0] exp_q [$];
    int          starts [$];
    int          cyc = 0;
    int          writes_seen = 0;
    int          last_stop = 0;
    int          done_rise = 0;
    int          n = 0;
    logic        in_xfer = 1'b0;
    logic [23:0] cur = '0;
    logic [26:0] bits = '0;
    int          nbits = 0;
    logic        prev_c = 1'b1, prev_oe = 1'b0, prev_done = 1'b0;

    // Bus monitor and per-cycle compare against the model.
    initial begin
        logic [1:0]  w;
        logic [23:0] got;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_xfer   = 1'b0;
                prev_c    = 1'b1;
                prev_oe   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (cfg_done && !prev_done) done_rise = cyc;
                check_eq("busy_and_done_exclusive", busy & cfg_done, 0);
                if (!in_xfer) begin
                    if (sio_c && sio_d_oe && prev_c && !prev_oe) begin
                        in_xfer = 1'b1;
                        n = 0;
                        nbits = 0;
                        starts.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: start condition with no write expected at cycle %0d", cyc);
                            cur = '0;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                    end else begin
                        check_eq("idle_sio_c", sio_c, 1);
                        check_eq("idle_sio_d_oe", sio_d_oe, 0);
                    end
                end
                if (in_xfer) begin
                    w = model_wave(n / QDIV, cur);
                    check_eq($sformatf("wave_sio_c_q%0d", n / QDIV), sio_c, w[1]);
                    check_eq($sformatf("wave_sio_d_oe_q%0d", n / QDIV), sio_d_oe, w[0]);
                    check_eq("busy_during_write", busy, 1);
                    checks++;
                    if (n != 0 && n != 112 * QDIV && prev_c && sio_c && (prev_oe != sio_d_oe)) begin
                        errors++;
                        $display("FAIL sio_d_toggle_while_c_high: quarter %0d, oe %0b -> %0b", n / QDIV, prev_oe, sio_d_oe);
                    end
                    if (!prev_c && sio_c && nbits < 27) begin
                        bits[26 - nbits] = ~sio_d_oe;
                        nbits++;
                    end
                    if (n == 112 * QDIV) last_stop = cyc;
                    n++;
                    if (n == XFER_Q * QDIV) begin
                        in_xfer = 1'b0;
                        writes_seen++;
                        got = {bits[26:19], bits[17:10], bits[8:1]};
                        $display("write %0d decoded %02h/%02h/%02h", writes_seen, got[23:16], got[15:8], got[7:0]);
                        check_eq("decoded_write_bytes", got, cur);
                        check_eq("decoded_bit_count", nbits, 27);
                    end
                end
                prev_c    = sio_c;
                prev_oe   = sio_d_oe;
                prev_done = cfg_done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic load_lut();
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'h0000;
        lut_mem[2] = 16'h1280;
        lut_mem[3] = 16'h0CD0;
        lut_mem[4] = 16'h1100;
        lut_mem[5] = 16'h1246;
    endtask

    task automatic push_writes(input int cnt);
        logic [23:0] tbl [4];
        tbl[0] = 24'h42_12_80;
        tbl[1] = 24'h42_0C_D0;
        tbl[2] = 24'h42_11_00;
        tbl[3] = 24'h42_12_46;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back(tbl[i]);
    endtask

    // Holds reset, checks reset values, releases; returns bookkeeping baselines.
    task automatic do_reset(output int sbase, output int wbase, output int rel);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_lut_index", lut_index, START_IDX);
        check_eq("rst_sio_c", sio_c, 1);
        check_eq("rst_sio_d_oe", sio_d_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cfg_done", cfg_done, 0);
        sbase = starts.size();
        wbase = writes_seen;
        rel   = cyc;
        rst   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!cfg_done && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (!cfg_done) begin
            errors++;
            $display("FAIL %s_timeout: cfg_done still 0 after %0d cycles", tag, k);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int sb, wb, rel, k;
        int i12, i23, i34;

        // Pin the model to hand-derived levels for 42/12/80.
        check_eq("model_q0", model_wave(0, 24'h421280), 2'b11);
        check_eq("model_q2", model_wave(2, 24'h421280), 2'b01);
        check_eq("model_q4", model_wave(4, 24'h421280), 2'b11);
        check_eq("model_q6", model_wave(6, 24'h421280), 2'b00);
        check_eq("model_q34_ack", model_wave(34, 24'h421280), 2'b00);
        check_eq("model_q38", model_wave(38, 24'h421280), 2'b01);
        check_eq("model_q110", model_wave(110, 24'h421280), 2'b01);
        check_eq("model_q112", model_wave(112, 24'h421280), 2'b10);

        // Full table after reset.
        load_lut();
        push_writes(4);
        do_reset(sb, wb, rel);
        repeat (3) @(negedge clk);
        #1;
        check_eq("pwrup_busy", busy, 1);
        check_eq("pwrup_cfg_done", cfg_done, 0);
        wait_done("full");
        check_eq("full_writes", writes_seen - wb, 4);
        check_eq("full_exp_left", exp_q.size(), 0);
        check_eq("full_busy_low", busy, 0);
        check_eq("full_lut_index", lut_index, 6);
        check_range("done_after_last_gap", done_rise - last_stop, GAP + QDIV, GAP + QDIV + 6);
        if (starts.size() >= sb + 4) begin
            check_range("first_start_after_pwrup", starts[sb] - rel, PWRUP, PWRUP + 8);
            i12 = starts[sb + 1] - starts[sb];
            i23 = starts[sb + 2] - starts[sb + 1];
            i34 = starts[sb + 3] - starts[sb + 2];
            check_eq("gap_uniform", i34, i23);
            check_eq("srst_extra_after_w1", i12 - i23, SRST_EXTRA);
            check_range("gap_min", i23, XFER_Q * QDIV + GAP, XFER_Q * QDIV + GAP + 8);
        end else begin
            checks++;
            errors++;
            $display("FAIL start_count: got %0d, expected 4", starts.size() - sb);
        end

        // Terminator at index 4.
        load_lut();
        lut_mem[4] = 16'h0000;
        push_writes(2);
        do_reset(sb, wb, rel);
        wait_done("term");
        check_eq("term_writes", writes_seen - wb, 2);
        check_eq("term_exp_left", exp_q.size(), 0);
        check_eq("term_lut_index", lut_index, 4);
        check_range("term_done_after_gap", done_rise - last_stop, GAP + QDIV, GAP + QDIV + 6);

        // Reset in the middle of write 2.
        load_lut();
        push_writes(4);
        do_reset(sb, wb, rel);
        k = 0;
        while (!(in_xfer && writes_seen - wb == 1 && n == 41) && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("abort_reached_q40", k < 3000, 1);
        rst = 1'b1;
        #1;
        check_eq("abort_sio_c", sio_c, 1);
        check_eq("abort_sio_d_oe", sio_d_oe, 0);
        push_writes(4);
        do_reset(sb, wb, rel);
        wait_done("abort");
        check_eq("abort_rerun_writes", writes_seen - wb, 4);
        check_eq("abort_exp_left", exp_q.size(), 0);

        // Start while busy is ignored; start after done re-runs everything.
        load_lut();
        push_writes(4);
        do_reset(sb, wb, rel);
        k = 0;
        while (!(in_xfer && writes_seen - wb == 1) && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        pulse_start();
        wait_done("busy_start");
        check_eq("busy_start_writes", writes_seen - wb, 4);
        check_eq("busy_start_exp_left", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        #1;
        check_eq("idle_cfg_done_held", cfg_done, 1);
        slave_addr = 8'h43;
        push_writes(4);
        wb = writes_seen;
        pulse_start();
        check_eq("restart_cfg_done_cleared", cfg_done, 0);
        check_eq("restart_busy", busy, 1);
        check_eq("restart_lut_index", lut_index, START_IDX);
        wait_done("restart");
        check_eq("restart_writes", writes_seen - wb, 4);
        check_eq("restart_exp_left", exp_q.size(), 0);
        check_eq("restart_lut_index_end", lut_index, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
